openhmc_bitslip_ctrl: RTL

OPENHMC_BITSLIP_CTRL -- requirements
Module: openhmc_bitslip_ctrl

---
 rtl/openhmc_bitslip_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/openhmc_bitslip_ctrl.sv
// openhmc_bitslip_ctrl: per-lane bitslip/lock sequencer; define BITSLIP_POLARITY_DETECT_EN to add lane polarity detection
module openhmc_bitslip_ctrl #(
    parameter int NUM_LANES   = 2,
    parameter int LANE_WIDTH  = 64,
    parameter int SLIP_WAIT   = 8,
    parameter int MATCH_COUNT = 4,
    parameter int MAX_SLIPS   = 128
) (
    input  logic                            clk_hmc,
    input  logic                            res,
    input  logic                            start,
    input  logic [LANE_WIDTH-1:0]           pattern,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] data_in,
    output logic [NUM_LANES-1:0]            bit_slip,
    output logic [NUM_LANES-1:0]            lane_polarity,
    output logic [NUM_LANES-1:0]            lane_locked,
    output logic                            all_locked,
    output logic                            fail
);
    localparam int MW = $clog2(MATCH_COUNT + 1);
    localparam int SW = $clog2(MAX_SLIPS + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_SLIP, S_WAIT, S_LOCKED, S_FAIL} state_t;

    logic [NUM_LANES-1:0] fail_l;

    assign all_locked = &lane_locked;
    assign fail       = |fail_l;

`ifndef BITSLIP_POLARITY_DETECT_EN
    assign lane_polarity = '0;
`endif

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        state_t                  state;
        logic [MW-1:0]           match_cnt;
        logic [SW-1:0]           slip_cnt;
        logic [7:0]              wait_cnt;
        logic                    slip_q;
        logic                    lock_q;
        logic                    fail_q;
        logic [LANE_WIDTH-1:0]   word;

        assign word           = data_in[l*LANE_WIDTH +: LANE_WIDTH];
        assign bit_slip[l]    = slip_q;
        assign lane_locked[l] = lock_q;
        assign fail_l[l]      = fail_q;

`ifdef BITSLIP_POLARITY_DETECT_EN
        logic pol_q;
        assign lane_polarity[l] = pol_q;
`endif

        // Lane FSM: compare, slip, settle, then lock or give up once the slip budget is spent
        always_ff @(posedge clk_hmc) begin
            slip_q <= 1'b0;
            if (res || start) begin
                state     <= res ? S_IDLE : S_CHECK;
                match_cnt <= '0;
                slip_cnt  <= '0;
                wait_cnt  <= '0;
                lock_q    <= 1'b0;
                fail_q    <= 1'b0;
`ifdef BITSLIP_POLARITY_DETECT_EN
                pol_q     <= 1'b0;
`endif
            end else begin
                case (state)
                    S_CHECK: begin
                        if (word == pattern) begin
                            match_cnt <= match_cnt + MW'(1);
                            if (match_cnt == MW'(MATCH_COUNT - 1)) begin
                                state  <= S_LOCKED;
                                lock_q <= 1'b1;
                            end
                        end
`ifdef BITSLIP_POLARITY_DETECT_EN
                        else if (word == ~pattern && !pol_q) begin
                            pol_q     <= 1'b1;
                            match_cnt <= '0;
                            wait_cnt  <= 8'(SLIP_WAIT - 1);
                            state     <= S_WAIT;
                        end
`endif
                        else if (slip_cnt < SW'(MAX_SLIPS)) begin
                            match_cnt <= '0;
                            slip_q    <= 1'b1;
                            state     <= S_SLIP;
                        end else begin
                            fail_q <= 1'b1;
                            state  <= S_FAIL;
                        end
                    end
                    S_SLIP: begin
                        slip_cnt <= slip_cnt + SW'(1);
                        wait_cnt <= 8'(SLIP_WAIT - 1);
                        state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        wait_cnt <= wait_cnt - 8'd1;
                        if (wait_cnt == 8'd0) state <= S_CHECK;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
